ahb_matrix_decoder_param: RTL and testbench

- Parametrised, N-output AHB bus-matrix input-side decoder.
- Decodes the address phase of one input port onto one of NUM_PORTS output stages, or onto an internal default slave.
- Registers the data-phase port select and multiplexes HREADYOUT/HRESP/HRDATA/HRUSER back to the input stage.
- Successor to the fixed two-port decoder. Adds:
  - parametrised port count and regions;
  - a run-time boot remap;
  - an integrated two-cycle ERROR default slave;
  - a sticky decode-error capture register.

---
 rtl/ahb_matrix_decoder_param.sv | 197 +++++++++++++++++++
 tb/tb_ahb_matrix_decoder_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_decoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_matrix_decoder_param
//  Description : Input-side decoder of an AHB bus matrix. Decodes the address
//                phase of one input port onto one of NUM_PORTS output stages
//                or onto an internal ERROR default slave. It registers the
//                data-phase port select and returns the selected stage's
//                response to the input stage. A sticky register captures the
//                address of the first decode error.
//
//  Ports       : HCLK / HRESET      clock, asynchronous active-high reset
//                HREADYS, sel_dec,  address phase from the input stage
//                decode_addr_dec,
//                trans_dec, remap
//                *_dec_vec inputs   per-output-stage active/response/data
//                sel_dec_vec        one-hot HSEL to the output stages
//                active_dec         active flag of the selected stage
//                HREADYOUTS, HRESPS,
//                HRDATAS, HRUSERS   data-phase response to the input stage
//                err_valid/err_addr sticky decode-error capture
//                err_clr            clears err_valid
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_matrix_decoder_param #(
   parameter int                        NUM_PORTS   = 4,
   parameter int                        PW          = 3,
   parameter logic [NUM_PORTS*22-1:0]   REGION_BASE = {NUM_PORTS{22'h0}},
   parameter logic [NUM_PORTS*22-1:0]   REGION_LAST = {NUM_PORTS{22'h0}},
   parameter int                        REMAP_PORT  = 1,
   parameter int                        DW          = 32
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      HREADYS,
   input  logic                      sel_dec,
   input  logic [21:0]               decode_addr_dec,
   input  logic [1:0]                trans_dec,
   input  logic                      remap,
   input  logic [NUM_PORTS-1:0]      active_dec_vec,
   input  logic [NUM_PORTS-1:0]      readyout_dec_vec,
   input  logic [2*NUM_PORTS-1:0]    resp_dec_vec,
   input  logic [DW*NUM_PORTS-1:0]   rdata_dec_vec,
   input  logic [DW*NUM_PORTS-1:0]   ruser_dec_vec,
   output logic [NUM_PORTS-1:0]      sel_dec_vec,
   output logic                      active_dec,
   output logic                      HREADYOUTS,
   output logic [1:0]                HRESPS,
   output logic [DW-1:0]             HRDATAS,
   output logic [DW-1:0]             HRUSERS,
   output logic                      err_valid,
   output logic [21:0]               err_addr,
   input  logic                      err_clr
);

   localparam logic [PW-1:0] c_def_port   = PW'(NUM_PORTS);
   localparam logic [PW-1:0] c_remap_port = PW'(REMAP_PORT);
   localparam logic [1:0]    c_trans_idle = 2'b00;
   localparam logic [1:0]    c_resp_okay  = 2'b00;
   localparam logic [1:0]    c_resp_error = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR1 = 2'd1,
      S_ERR2 = 2'd2
   } dflt_state_t;

   dflt_state_t          r_state;
   dflt_state_t          w_state_nxt;
   logic [PW-1:0]        r_data_port;
   logic                 r_err_valid;
   logic [21:0]          r_err_addr;

   logic [NUM_PORTS-1:0] w_hit;
   logic [PW-1:0]        w_addr_port;
   logic                 w_dflt_xfer;
   logic                 w_err_event;

   // ------------------------------------------------------------------------
   // Region hit flags; an empty region (last < base) can never satisfy both
   // unsigned compares.
   // ------------------------------------------------------------------------
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_hit[i] = (decode_addr_dec >= REGION_BASE[i*22 +: 22]) &&
                    (decode_addr_dec <= REGION_LAST[i*22 +: 22]);
      end
   end

   // ------------------------------------------------------------------------
   // Address-phase port code. IDLE keeps the current data-phase port so the
   // selected stage does not toggle between bursts. The priority loop runs
   // downwards so the lowest overlapping region wins.
   // ------------------------------------------------------------------------
   always_comb begin
      w_addr_port = c_def_port;
      if (trans_dec == c_trans_idle) begin
         w_addr_port = r_data_port;
      end else if (remap && w_hit[0]) begin
         w_addr_port = c_remap_port;
      end else begin
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
               w_addr_port = PW'(i);
            end
         end
      end
   end

   // Select and active flag; codes without a real port drive no select.
   always_comb begin
      sel_dec_vec = '0;
      active_dec  = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_addr_port == PW'(i)) begin
            sel_dec_vec[i] = sel_dec;
            active_dec     = active_dec_vec[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Data-phase port register
   // ------------------------------------------------------------------------
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_data_port <= '0;
      end else if (HREADYS) begin
         r_data_port <= w_addr_port;
      end
   end

   // ------------------------------------------------------------------------
   // Data-phase response mux; the default slave supplies the fallback values.
   // ------------------------------------------------------------------------
   always_comb begin
      HREADYOUTS = (r_state != S_ERR1);
      HRESPS     = (r_state == S_IDLE) ? c_resp_okay : c_resp_error;
      HRDATAS    = '0;
      HRUSERS    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_data_port == PW'(i)) begin
            HREADYOUTS = readyout_dec_vec[i];
            HRESPS     = resp_dec_vec[2*i +: 2];
            HRDATAS    = rdata_dec_vec[DW*i +: DW];
            HRUSERS    = ruser_dec_vec[DW*i +: DW];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Default slave: two-cycle ERROR response to NONSEQ/SEQ transfers.
   // ------------------------------------------------------------------------
   assign w_dflt_xfer = sel_dec & HREADYS & trans_dec[1] & (w_addr_port == c_def_port);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_dflt_xfer ? S_ERR1 : S_IDLE;
         S_ERR1:  w_state_nxt = S_ERR2;
         S_ERR2:  w_state_nxt = w_dflt_xfer ? S_ERR1 : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // An error event is any entry into ERR1 (from IDLE or ERR2).
   assign w_err_event = w_dflt_xfer && (r_state != S_ERR1);

   // ------------------------------------------------------------------------
   // Sticky error capture; a coinciding clear and new error keeps the new one.
   // ------------------------------------------------------------------------
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
      end else if (w_err_event && (!r_err_valid || err_clr)) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= decode_addr_dec;
      end else if (err_clr) begin
         r_err_valid <= 1'b0;
      end
   end

   assign err_valid = r_err_valid;
   assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahb_matrix_decoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_matrix_decoder_param
//  Description : Self-checking bench for ahb_matrix_decoder_param with four
//                ports: port0 0x000-0x03F, port1 0x040-0x07F, ports 2 and 3
//                both 0x100-0x13F (in 1 KB units), REMAP_PORT = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_matrix_decoder_param;

   localparam int NP = 4;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          HREADYS;
   logic          sel_dec;
   logic [31:0]   haddr;
   logic [21:0]   decode_addr_dec;
   logic [1:0]    trans_dec;
   logic          remap;
   logic [NP-1:0] active_dec_vec;
   logic [NP-1:0] readyout_dec_vec;
   logic [2*NP-1:0]  resp_dec_vec;
   logic [32*NP-1:0] rdata_dec_vec;
   logic [32*NP-1:0] ruser_dec_vec;
   logic [NP-1:0] sel_dec_vec;
   logic          active_dec;
   logic          HREADYOUTS;
   logic [1:0]    HRESPS;
   logic [31:0]   HRDATAS;
   logic [31:0]   HRUSERS;
   logic          err_valid;
   logic [21:0]   err_addr;
   logic          err_clr;

   assign decode_addr_dec = haddr[31:10];

   ahb_matrix_decoder_param #(
      .NUM_PORTS   (NP),
      .PW          (3),
      .REGION_BASE ({22'h100, 22'h100, 22'h040, 22'h000}),
      .REGION_LAST ({22'h13F, 22'h13F, 22'h07F, 22'h03F}),
      .REMAP_PORT  (1),
      .DW          (32)
   ) u_dut (
      .HCLK             (HCLK),
      .HRESET           (HRESET),
      .HREADYS          (HREADYS),
      .sel_dec          (sel_dec),
      .decode_addr_dec  (decode_addr_dec),
      .trans_dec        (trans_dec),
      .remap            (remap),
      .active_dec_vec   (active_dec_vec),
      .readyout_dec_vec (readyout_dec_vec),
      .resp_dec_vec     (resp_dec_vec),
      .rdata_dec_vec    (rdata_dec_vec),
      .ruser_dec_vec    (ruser_dec_vec),
      .sel_dec_vec      (sel_dec_vec),
      .active_dec       (active_dec),
      .HREADYOUTS       (HREADYOUTS),
      .HRESPS           (HRESPS),
      .HRDATAS          (HRDATAS),
      .HRUSERS          (HRUSERS),
      .err_valid        (err_valid),
      .err_addr         (err_addr),
      .err_clr          (err_clr)
   );

   always #5 HCLK = ~HCLK;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   typedef struct {
      logic [31:0] haddr;
      logic [1:0]  trans;
      logic        remap;
      logic        sel;
      logic [3:0]  exp_vec;
      logic        exp_act;
      int          exp_port;
   } vec_t;

   typedef struct {
      logic        rdy;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [31:0] ruser;
   } dp_t;

   vec_t tv [12];
   dp_t  sb [$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Stage configuration held in variables so the bench can index it.
   logic [3:0] cfg_rdy = 4'b1011;
   logic [3:0] cfg_act = 4'b0101;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic [31:0] a, input logic [1:0] t, input logic s,
                      input logic rm, input logic hr, input logic clr);
      haddr     = a;
      trans_dec = t;
      sel_dec   = s;
      remap     = rm;
      HREADYS   = hr;
      err_clr   = clr;
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   task automatic dchk(input string tag, input logic rdy, input logic [1:0] resp);
      chk({tag, ".ready"}, HREADYOUTS, rdy);
      chk({tag, ".resp"},  HRESPS,     resp);
   endtask

   function automatic dp_t exp_dp(input int p);
      dp_t d;
      if (p < NP) begin
         d.rdy   = cfg_rdy[p];
         d.resp  = 2'(p);
         d.rdata = 32'hA5A5_0000 | 32'(p);
         d.ruser = 32'h5A5A_0000 | 32'(p);
      end else begin
         d.rdy   = 1'b1;
         d.resp  = 2'b00;
         d.rdata = '0;
         d.ruser = '0;
      end
      return d;
   endfunction

   initial begin
      dp_t e;
      tv[0]  = '{32'h0001_0000, T_NSEQ, 1'b0, 1'b1, 4'b0010, 1'b0, 1};
      tv[1]  = '{32'h0000_0400, T_NSEQ, 1'b1, 1'b1, 4'b0010, 1'b0, 1};
      tv[2]  = '{32'h0000_0400, T_NSEQ, 1'b0, 1'b1, 4'b0001, 1'b1, 0};
      tv[3]  = '{32'h0004_0000, T_NSEQ, 1'b0, 1'b1, 4'b0100, 1'b1, 2};
      tv[4]  = '{32'h2000_0000, T_IDLE, 1'b0, 1'b1, 4'b0100, 1'b1, 2};
      tv[5]  = '{32'h0004_FC00, T_SEQ,  1'b0, 1'b1, 4'b0100, 1'b1, 2};
      tv[6]  = '{32'h0005_0000, T_NSEQ, 1'b0, 1'b0, 4'b0000, 1'b1, 4};
      tv[7]  = '{32'h0003_FC00, T_BUSY, 1'b0, 1'b1, 4'b0000, 1'b1, 4};
      tv[8]  = '{32'h0001_FC00, T_NSEQ, 1'b0, 1'b1, 4'b0010, 1'b0, 1};
      tv[9]  = '{32'h0002_0000, T_IDLE, 1'b0, 1'b1, 4'b0010, 1'b0, 1};
      tv[10] = '{32'h0000_FC00, T_NSEQ, 1'b1, 1'b1, 4'b0010, 1'b0, 1};
      tv[11] = '{32'h0001_0000, T_NSEQ, 1'b1, 1'b1, 4'b0010, 1'b0, 1};

      active_dec_vec   = cfg_act;
      readyout_dec_vec = cfg_rdy;
      resp_dec_vec     = {2'd3, 2'd2, 2'd1, 2'd0};
      rdata_dec_vec    = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
      ruser_dec_vec    = {32'h5A5A_0003, 32'h5A5A_0002, 32'h5A5A_0001, 32'h5A5A_0000};
      HRESET = 1'b1;
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) nxt();

      // Reset state
      chk("rst.err_valid", err_valid, 1'b0);
      chk("rst.err_addr",  err_addr,  22'h0);
      chk("rst.sel_vec",   sel_dec_vec, 4'b0000);
      chk("rst.ready",     HREADYOUTS, 1'b1);
      chk("rst.rdata",     HRDATAS, 32'hA5A5_0000);
      chk("rst.ruser",     HRUSERS, 32'h5A5A_0000);
      HRESET = 1'b0;

      // Table: decode checked in the address phase, response one cycle later.
      for (int k = 0; k < 12; k++) begin
         drv(tv[k].haddr, tv[k].trans, tv[k].sel, tv[k].remap, 1'b1, 1'b0);
         @(negedge HCLK);
         chk($sformatf("tv%0d.sel_vec", k), sel_dec_vec, tv[k].exp_vec);
         chk($sformatf("tv%0d.active", k),  active_dec,  tv[k].exp_act);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("tv%0d.dp_ready", k), HREADYOUTS, e.rdy);
            chk($sformatf("tv%0d.dp_resp", k),  HRESPS,     e.resp);
            chk($sformatf("tv%0d.dp_rdata", k), HRDATAS,    e.rdata);
            chk($sformatf("tv%0d.dp_ruser", k), HRUSERS,    e.ruser);
         end
         sb.push_back(exp_dp(tv[k].exp_port));
         nxt();
      end
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      e = sb.pop_front();
      chk("tvlast.dp_ready", HREADYOUTS, e.rdy);
      chk("tvlast.dp_rdata", HRDATAS,    e.rdata);
      chk("tv.no_err",       err_valid,  1'b0);
      nxt();

      // Single decode error: two-cycle ERROR response and capture.
      drv(32'h2000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      chk("e1.sel_vec", sel_dec_vec, 4'b0000);
      chk("e1.active",  active_dec,  1'b1);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      dchk("e1.err1", 1'b0, 2'b01);
      chk("e1.err_valid", err_valid, 1'b1);
      chk("e1.err_addr",  err_addr,  22'h080000);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      dchk("e1.err2", 1'b1, 2'b01);
      chk("e1.rdata", HRDATAS, 32'h0);
      nxt();
      @(negedge HCLK);
      dchk("e1.idle", 1'b1, 2'b00);
      nxt();

      // Back-to-back errors, sticky capture, clear, clear-with-capture.
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
      nxt();
      drv(32'h3000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      chk("b.cleared", err_valid, 1'b0);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      dchk("b.err1a", 1'b0, 2'b01);
      nxt();
      drv(32'h4000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      dchk("b.err2a", 1'b1, 2'b01);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      dchk("b.err1b", 1'b0, 2'b01);
      chk("b.keep_addr", err_addr, 22'h0C0000);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge HCLK);
      dchk("b.err2b", 1'b1, 2'b01);
      nxt();
      drv(32'h5000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      chk("b.clr_valid", err_valid, 1'b0);
      dchk("b.idle", 1'b1, 2'b00);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      chk("b.third_valid", err_valid, 1'b1);
      chk("b.third_addr",  err_addr,  22'h140000);
      nxt();
      drv(32'h6000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge HCLK);
      dchk("b.err2c", 1'b1, 2'b01);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      chk("b.coinc_valid", err_valid, 1'b1);
      chk("b.coinc_addr",  err_addr,  22'h180000);
      dchk("b.err1c", 1'b0, 2'b01);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
      nxt();

      // Asynchronous reset during ERR1.
      drv(32'h7000_0000, T_NSEQ, 1'b1, 1'b0, 1'b1, 1'b0);
      nxt();
      drv(32'h0001_0000, T_NSEQ, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge HCLK);
      chk("r.pre_ready", HREADYOUTS, 1'b0);
      #1 HRESET = 1'b1;
      #1;
      chk("r.ready",     HREADYOUTS, 1'b1);
      chk("r.resp",      HRESPS,     2'b00);
      chk("r.rdata",     HRDATAS,    32'hA5A5_0000);
      chk("r.sel_vec",   sel_dec_vec, 4'b0010);
      chk("r.err_valid", err_valid,  1'b0);
      chk("r.err_addr",  err_addr,   22'h0);
      nxt();
      HRESET = 1'b0;
      drv(32'h2000_0000, T_IDLE, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      chk("r.idle_sel", sel_dec_vec, 4'b0001);
      dchk("r.post", 1'b1, 2'b00);
      nxt();
      drv(32'h2000_0000, T_BUSY, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      chk("r.busy_sel", sel_dec_vec, 4'b0000);
      chk("r.busy_act", active_dec,  1'b1);
      nxt();
      drv(32'h0, T_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      dchk("r.busy_dp", 1'b1, 2'b00);
      chk("r.busy_rdata", HRDATAS,   32'h0);
      chk("r.busy_noerr", err_valid, 1'b0);
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
